// File: rtl/alu_seq_param_pkg.sv
// Shared definitions for the sequential ALU: opcode encoding and controller state codes.
package alu_seq_param_pkg;

  // 4-bit command encoding, unchanged from the combinational predecessor
  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_INC  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_DEC  = 4'h3;
  localparam logic [3:0] OP_MUL  = 4'h4;
  localparam logic [3:0] OP_DIV  = 4'h5;
  localparam logic [3:0] OP_SHL  = 4'h6;
  localparam logic [3:0] OP_SHR  = 4'h7;
  localparam logic [3:0] OP_AND  = 4'h8;
  localparam logic [3:0] OP_OR   = 4'h9;
  localparam logic [3:0] OP_INV  = 4'hA;
  localparam logic [3:0] OP_NAND = 4'hB;
  localparam logic [3:0] OP_NOR  = 4'hC;
  localparam logic [3:0] OP_XOR  = 4'hD;
  localparam logic [3:0] OP_XNOR = 4'hE;
  localparam logic [3:0] OP_BUF  = 4'hF;

  // Controller states: idle/accepting, or waiting on the divider
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_DIV  = 1'b1;

  // True for commands whose carry flag comes from bit WIDTH of the result
  function automatic logic op_carry_from_msb(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_INC) || (op == OP_SUB) ||
           (op == OP_DEC) || (op == OP_SHL);
  endfunction

endpackage

// File: rtl/alu_divider.sv
// Restoring shift-subtract divider: one quotient bit per clock, WIDTH clocks per divide.
// valid/quotient/remainder are combinational on the final iteration so the caller can
// register the finished result on the same edge the last bit is produced.
module alu_divider #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             valid,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int unsigned CW = $clog2(WIDTH);

  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dsr_q;
  logic [CW-1:0]    count_q;
  logic             run_q;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic             fits;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_next;

  // One restoring step: shift next dividend bit into the partial remainder, trial subtract
  always_comb begin
    shifted  = {rem_q, quo_q[WIDTH-1]};
    diff     = shifted - {1'b0, dsr_q};
    fits     = (shifted >= {1'b0, dsr_q});
    rem_next = fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    quo_next = {quo_q[WIDTH-2:0], fits};
  end

  assign busy      = run_q;
  assign valid     = run_q && (count_q == '0);
  assign quotient  = quo_next;
  assign remainder = rem_next;

  // Iteration state: load primes the registers, then one step per clock until count hits 0
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rem_q   <= '0;
      quo_q   <= '0;
      dsr_q   <= '0;
      count_q <= '0;
      run_q   <= 1'b0;
    end else if (load) begin
      rem_q   <= '0;
      quo_q   <= dividend;
      dsr_q   <= divisor;
      count_q <= CW'(WIDTH - 1);
      run_q   <= 1'b1;
    end else if (run_q) begin
      rem_q <= rem_next;
      quo_q <= quo_next;
      if (count_q == '0) begin
        run_q <= 1'b0;
      end else begin
        count_q <= count_q - 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_seq_param.sv
// Clocked 16-command ALU with start/busy/done handshake, multi-cycle divide and
// registered result/flags. d_out is released to high impedance when oe is low.
module alu_seq_param
  import alu_seq_param_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [3:0]         command_in,
  input  logic [WIDTH-1:0]   a_in,
  input  logic [WIDTH-1:0]   b_in,
  input  logic               oe,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] d_out,
  output logic               zero,
  output logic               carry,
  output logic               div_zero
);

  logic [0:0]         state;
  logic [2*WIDTH-1:0] result;

  logic [2*WIDTH-1:0] op_result;
  logic               op_carry;
  logic               op_div_fault;
  logic [WIDTH:0]     ext;

  logic               div_go;
  logic               div_busy;
  logic               div_valid;
  logic [WIDTH-1:0]   div_quo;
  logic [WIDTH-1:0]   div_rem;
  logic [2*WIDTH-1:0] div_result;

  // Single-cycle command results; DIV here only covers the divide-by-zero fault case
  always_comb begin
    op_result    = '0;
    op_carry     = 1'b0;
    op_div_fault = 1'b0;
    ext          = '0;
    case (command_in)
      OP_ADD:  ext = {1'b0, a_in} + {1'b0, b_in};
      OP_INC:  ext = {1'b0, a_in} + {{WIDTH{1'b0}}, 1'b1};
      OP_SUB:  ext = {1'b0, a_in} - {1'b0, b_in};
      OP_DEC:  ext = {1'b0, a_in} - {{WIDTH{1'b0}}, 1'b1};
      OP_SHL:  ext = {a_in, 1'b0};
      OP_SHR:  ext = {2'b00, a_in[WIDTH-1:1]};
      OP_AND:  ext = {1'b0, a_in & b_in};
      OP_OR:   ext = {1'b0, a_in | b_in};
      OP_INV:  ext = {1'b0, ~a_in};
      OP_NAND: ext = {1'b0, ~(a_in & b_in)};
      OP_NOR:  ext = {1'b0, ~(a_in | b_in)};
      OP_XOR:  ext = {1'b0, a_in ^ b_in};
      OP_XNOR: ext = {1'b0, ~(a_in ^ b_in)};
      OP_BUF:  ext = {1'b0, a_in};
      default: ext = '0;
    endcase

    op_result = {{(WIDTH-1){1'b0}}, ext};
    if (op_carry_from_msb(command_in)) begin
      op_carry = ext[WIDTH];
    end

    if (command_in == OP_SHR) begin
      op_carry = a_in[0];
    end else if (command_in == OP_MUL) begin
      op_result = {{WIDTH{1'b0}}, a_in} * {{WIDTH{1'b0}}, b_in};
    end else if (command_in == OP_DIV) begin
      // Only reaches the result register when b_in is zero
      op_result    = {a_in, {WIDTH{1'b1}}};
      op_div_fault = 1'b1;
    end
  end

  assign div_go     = (state == ST_IDLE) && start && (command_in == OP_DIV) && (b_in != '0);
  assign div_result = {div_rem, div_quo};

  alu_divider #(
    .WIDTH(WIDTH)
  ) u_divider (
    .clock     (clock),
    .reset     (reset),
    .load      (div_go),
    .dividend  (a_in),
    .divisor   (b_in),
    .busy      (div_busy),
    .valid     (div_valid),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  assign busy = div_busy;

  // Controller: accept when idle, load result/flags at completion, pulse done for one cycle
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      result   <= '0;
      zero     <= 1'b0;
      carry    <= 1'b0;
      div_zero <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (div_go) begin
            state <= ST_DIV;
          end else if (start) begin
            result   <= op_result;
            zero     <= (op_result == '0);
            carry    <= op_carry;
            div_zero <= op_div_fault;
            done     <= 1'b1;
          end
        end
        ST_DIV: begin
          if (div_valid) begin
            result   <= div_result;
            zero     <= (div_result == '0);
            carry    <= 1'b0;
            div_zero <= 1'b0;
            done     <= 1'b1;
            state    <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign d_out = oe ? result : {(2*WIDTH){1'bz}};

endmodule

// File: tb/tb_alu_seq_param.sv
// Self-checking bench for alu_seq_param: directed cases plus random commands compared
// against an arithmetic reference model; a second instance covers WIDTH=4.
module tb_alu_seq_param;
  import alu_seq_param_pkg::*;

  logic        clock;
  logic        reset;
  logic        start;
  logic [3:0]  command_in;
  logic [7:0]  a_in;
  logic [7:0]  b_in;
  logic        oe;
  logic        busy;
  logic        done;
  wire  [15:0] d_out;
  logic        zero;
  logic        carry;
  logic        div_zero;

  logic        start4;
  logic [3:0]  command_in4;
  logic [3:0]  a_in4;
  logic [3:0]  b_in4;
  logic        busy4;
  logic        done4;
  wire  [7:0]  d_out4;
  logic        zero4;
  logic        carry4;
  logic        div_zero4;

  int tests = 0;
  int fails = 0;

  alu_seq_param #(.WIDTH(8)) dut (
    .clock(clock), .reset(reset), .start(start), .command_in(command_in),
    .a_in(a_in), .b_in(b_in), .oe(oe), .busy(busy), .done(done),
    .d_out(d_out), .zero(zero), .carry(carry), .div_zero(div_zero)
  );

  alu_seq_param #(.WIDTH(4)) dut4 (
    .clock(clock), .reset(reset), .start(start4), .command_in(command_in4),
    .a_in(a_in4), .b_in(b_in4), .oe(1'b1), .busy(busy4), .done(done4),
    .d_out(d_out4), .zero(zero4), .carry(carry4), .div_zero(div_zero4)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic string op_name(input logic [3:0] c);
    case (c)
      OP_ADD: return "ADD";   OP_INC: return "INC";   OP_SUB: return "SUB";
      OP_DEC: return "DEC";   OP_MUL: return "MUL";   OP_DIV: return "DIV";
      OP_SHL: return "SHL";   OP_SHR: return "SHR";   OP_AND: return "AND";
      OP_OR:  return "OR";    OP_INV: return "INV";   OP_NAND: return "NAND";
      OP_NOR: return "NOR";   OP_XOR: return "XOR";   OP_XNOR: return "XNOR";
      default: return "BUF";
    endcase
  endfunction

  // Reference: plain integer arithmetic on the command definitions
  function automatic void model(input logic [3:0] c, input int unsigned a, input int unsigned b,
                                input int unsigned w, output int unsigned res, output bit cy);
    int unsigned mask;
    int unsigned m1;
    mask = (32'd1 << w) - 1;
    m1   = (32'd1 << (w + 1)) - 1;
    case (c)
      OP_ADD:  res = a + b;
      OP_INC:  res = a + 1;
      OP_SUB:  res = (a - b) & m1;
      OP_DEC:  res = (a - 1) & m1;
      OP_MUL:  res = a * b;
      OP_DIV:  res = (b == 0) ? ((a << w) | mask) : (((a % b) << w) | (a / b));
      OP_SHL:  res = a << 1;
      OP_SHR:  res = a >> 1;
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_INV:  res = ~a & mask;
      OP_NAND: res = ~(a & b) & mask;
      OP_NOR:  res = ~(a | b) & mask;
      OP_XOR:  res = a ^ b;
      OP_XNOR: res = ~(a ^ b) & mask;
      default: res = a;
    endcase
    case (c)
      OP_ADD, OP_INC, OP_SUB, OP_DEC, OP_SHL: cy = ((res >> w) & 1) != 0;
      OP_SHR:  cy = (a & 1) != 0;
      default: cy = 1'b0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one command on the WIDTH=8 instance and check timing, result and flags
  task automatic run_op(input logic [3:0] c, input logic [7:0] a, input logic [7:0] b);
    int unsigned er;
    bit ec;
    int cycles;
    string n;
    model(c, a, b, 8, er, ec);
    n = op_name(c);
    @(negedge clock);
    start = 1'b1; command_in = c; a_in = a; b_in = b;
    @(posedge clock); #1;
    start = 1'b0;
    if (c == OP_DIV && b != 0) begin
      cycles = 0;
      while (done !== 1'b1 && cycles < 20) begin
        check({n, " busy_while_dividing"}, busy, 1);
        @(posedge clock); #1;
        cycles++;
      end
      check({n, " div_latency"}, cycles, 8);
    end
    check({n, " done"}, done, 1);
    check({n, " busy_at_done"}, busy, 0);
    check({n, " d_out"}, d_out, er);
    check({n, " carry"}, carry, ec);
    check({n, " zero"}, zero, er == 0);
    check({n, " div_zero"}, div_zero, (c == OP_DIV && b == 0));
    @(posedge clock); #1;
    check({n, " done_single_pulse"}, done, 0);
  endtask

  task automatic run_op4(input logic [3:0] c, input logic [3:0] a, input logic [3:0] b);
    int unsigned er;
    bit ec;
    int cycles;
    string n;
    model(c, a, b, 4, er, ec);
    n = {"W4 ", op_name(c)};
    @(negedge clock);
    start4 = 1'b1; command_in4 = c; a_in4 = a; b_in4 = b;
    @(posedge clock); #1;
    start4 = 1'b0;
    cycles = 0;
    while (done4 !== 1'b1 && cycles < 20) begin
      @(posedge clock); #1;
      cycles++;
    end
    check({n, " latency"}, cycles, (c == OP_DIV && b != 0) ? 4 : 0);
    check({n, " d_out"}, d_out4, er);
    check({n, " carry"}, carry4, ec);
  endtask

  initial begin
    int cycles;
    bit saw_done;
    logic [3:0] rc;
    logic [7:0] ra;
    logic [7:0] rb;

    reset = 1'b1; start = 1'b0; command_in = '0; a_in = '0; b_in = '0; oe = 1'b1;
    start4 = 1'b0; command_in4 = '0; a_in4 = '0; b_in4 = '0;
    repeat (3) @(posedge clock);
    #1;
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset d_out", d_out, 16'h0000);
    check("reset zero", zero, 0);
    check("reset carry", carry, 0);
    check("reset div_zero", div_zero, 0);
    check("reset W4 d_out", d_out4, 8'h00);
    @(negedge clock);
    reset = 1'b0;

    // Directed cases with literal expectations
    run_op(OP_ADD, 8'd200, 8'd100);
    check("spec ADD d_out", d_out, 16'h012C);
    check("spec ADD carry", carry, 1);
    run_op(OP_SUB, 8'd5, 8'd10);
    check("spec SUB d_out", d_out, 16'h01FB);
    run_op(OP_MUL, 8'd255, 8'd255);
    check("spec MUL d_out", d_out, 16'hFE01);
    run_op(OP_DEC, 8'd0, 8'd0);
    check("spec DEC d_out", d_out, 16'h01FF);
    run_op(OP_AND, 8'h0F, 8'hF0);
    check("spec AND zero", zero, 1);
    run_op(OP_DIV, 8'd200, 8'd7);
    check("spec DIV d_out", d_out, 16'h041C);
    run_op(OP_DIV, 8'd200, 8'd0);
    check("spec DIV0 d_out", d_out, 16'hC8FF);
    check("spec DIV0 div_zero", div_zero, 1);
    run_op(OP_ADD, 8'd1, 8'd1);
    check("spec ADD clears div_zero", div_zero, 0);
    run_op(OP_SHL, 8'h81, 8'd0);
    run_op(OP_SHR, 8'h81, 8'd0);
    run_op(OP_INC, 8'hFF, 8'd0);

    // start while busy is dropped, DIV result survives
    @(negedge clock);
    start = 1'b1; command_in = OP_DIV; a_in = 8'd200; b_in = 8'd7;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    start = 1'b1; command_in = OP_ADD; a_in = 8'd1; b_in = 8'd1;
    @(posedge clock); #1;
    start = 1'b0;
    check("ignored start busy", busy, 1);
    check("ignored start done", done, 0);
    cycles = 0;
    while (done !== 1'b1 && cycles < 20) begin
      @(posedge clock); #1;
      cycles++;
    end
    check("ignored start div done", done, 1);
    check("ignored start d_out", d_out, 16'h041C);
    saw_done = 1'b0;
    repeat (4) begin
      @(posedge clock); #1;
      if (done === 1'b1) saw_done = 1'b1;
    end
    check("ignored start no queued op", saw_done, 0);

    // Accept in the same cycle done is high
    @(negedge clock);
    start = 1'b1; command_in = OP_ADD; a_in = 8'd3; b_in = 8'd4;
    @(posedge clock); #1;
    check("b2b first done", done, 1);
    command_in = OP_SUB; a_in = 8'd9; b_in = 8'd2;
    @(posedge clock); #1;
    start = 1'b0;
    check("b2b second done", done, 1);
    check("b2b second d_out", d_out, 16'h0007);
    @(posedge clock); #1;
    check("b2b done drops", done, 0);

    // Reset three cycles into a divide aborts it
    @(negedge clock);
    start = 1'b1; command_in = OP_DIV; a_in = 8'd200; b_in = 8'd7;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (3) @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    check("abort busy", busy, 0);
    check("abort done", done, 0);
    check("abort d_out", d_out, 16'h0000);
    check("abort zero", zero, 0);
    check("abort carry", carry, 0);
    check("abort div_zero", div_zero, 0);
    @(negedge clock);
    reset = 1'b0;
    saw_done = 1'b0;
    repeat (12) begin
      @(posedge clock); #1;
      if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
    end
    check("abort no done or busy", saw_done, 0);

    // Output enable gates only d_out
    run_op(OP_XOR, 8'hA5, 8'h0F);
    @(negedge clock);
    oe = 1'b0;
    #1;
    tests++;
    assert ((d_out === 16'hzzzz) || (d_out === 16'h0000)) else begin
      fails++;
      $error("FAIL oe_off d_out observed=0x%0h expected=high-z", d_out);
    end
    check("oe_off zero", zero, 0);
    check("oe_off busy", busy, 0);
    @(negedge clock);
    oe = 1'b1;
    #1;
    check("oe_on d_out", d_out, 16'h00AA);

    // Random commands against the model
    for (int i = 0; i < 60; i++) begin
      rc = 4'($urandom_range(0, 15));
      ra = 8'($urandom_range(0, 255));
      rb = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
      run_op(rc, ra, rb);
    end

    // WIDTH=4 instance
    run_op4(OP_MUL, 4'd15, 4'd15);
    check("spec W4 MUL d_out", d_out4, 8'hE1);
    run_op4(OP_DIV, 4'd15, 4'd4);
    check("spec W4 DIV d_out", d_out4, 8'h33);
    run_op4(OP_SUB, 4'd0, 4'd1);
    run_op4(OP_DIV, 4'd9, 4'd0);
    check("W4 DIV0 div_zero", div_zero4, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
